pwm_duty_ctrl: RTL and testbench
================================

Name: pwm_duty_ctrl

Overview:
- Front-end controller for the PWM duty-cycle datapath.
- Takes the raw increase/decrease push-button pins, synchronises and debounces them, and turns presses into saturating duty steps, with auto-repeat while a button is held.
- Holds a target duty and hands it to the PWM counter only at a period boundary, so the PWM never sees a mid-period duty change.
- Sits between the chip inputs and the PWM generator inside top.

Parameters:
- DUTY_W, 4, width of the duty value; max duty = 2^DUTY_W-1.
- DUTY_RESET, 8, duty value after reset.
- STEP, 1, amount added/subtracted per step.
- DEB_CYCLES, 4, consecutive stable synced samples needed to accept a button level change (>=2).
- REPEAT_CYCLES, 16, clock cycles between auto-repeat steps while held (>=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- inc_in  in  1  raw increase button, asynchronous, active-high.
- dec_in  in  1  raw decrease button, asynchronous, active-high.
- period_end  in  1  one-cycle pulse from PWM counter at last count of a period.
- duty  out  DUTY_W  duty value presented to the PWM generator.
- duty_pending  out  1  target differs from duty.
- at_max  out  1  target == 2^DUTY_W-1.
- at_min  out  1  target == 0.

Behaviour:
- Reset (async assert, sync release): sync flops, debounced levels and all counters cleared; FSM=IDLE; target=duty=DUTY_RESET.
  - Reset outputs: duty=DUTY_RESET, duty_pending=0; at_max/at_min per DUTY_RESET (both 0 at defaults).
  - Reset mid-operation takes effect immediately; no step is generated on release even if a button is still held, until that button has been debounced low and pressed again.
- Sync: 2-flop synchroniser per button.
- Debounce, per button:
  - Counter increments while synced sample != debounced level; clears when they are equal.
  - Debounced level flips on the DEB_CYCLES-th consecutive differing sample; counter clears on the flip.
- FSM on debounced inc (I) and dec (D):
  - IDLE:
    - I&!D -> HELD_INC and step +STEP.
    - D&!I -> HELD_DEC and step -STEP.
    - I&D -> LOCK, no step.
  - HELD_x:
    - Repeat counter loads REPEAT_CYCLES on entry and decrements each cycle; at 1 it issues a step and reloads.
    - Own button released -> IDLE.
    - Other button asserted -> LOCK, no step that cycle.
  - LOCK: stays until !I&!D, then -> IDLE. No steps are issued in LOCK.
- Step applies to target on the same edge as the FSM transition:
  - Inc: target = min(target+STEP, 2^DUTY_W-1).
  - Dec: target = max(target-STEP, 0).
  - Arithmetic is done one bit wider, then clamped; never wraps.
  - A step at a limit leaves target unchanged; FSM timing is unaffected.
- Latency: if a raw pin is stable high from edge k, target changes at edge k+DEB_CYCLES+2. Repeats follow at +n*REPEAT_CYCLES.
- Handoff:
  - On an edge with period_end=1, duty <= target (value before any same-edge step).
  - If a step and period_end coincide, duty takes the old target and duty_pending stays 1 until the next period_end.
  - duty_pending = (target != duty), registered-equivalent.
  - at_max/at_min are derived from target.
- period_end asserted for several consecutive cycles: duty reloads every such cycle. This is harmless.

Test Plan:
1. Apply reset with no buttons -> duty=8, duty_pending=0, at_max=0, at_min=0. Also assert reset asynchronously between clock edges -> outputs return to reset values before the next edge.
2. inc_in high from edge k for 10 cycles, period_end every 32 cycles:
   - target=9 at edge k+6 and duty_pending=1 from then.
   - duty=9 at the next period_end edge, then duty_pending=0.
   - Exactly one step.
3. inc_in glitch high for 3 cycles, or toggling every cycle for 20 cycles -> no step; duty stays 8.
4. dec_in held 200 cycles with period_end every 8 cycles:
   - Steps at k+6, k+22, k+38, ...
   - duty reaches 0 and at_min=1.
   - Further repeats keep 0; no wrap to 15.
   - Mirror test with inc saturates at 15 with at_max=1.
5. Both buttons pressed together -> LOCK, no step. Release inc with dec still held -> still no step. Release both, then press dec -> one decrement.
6. Step coinciding with a period_end pulse -> duty loads the pre-step value and duty_pending=1 until the following period_end. Reset asserted during HELD_INC with inc_in still high -> after release, no step until inc_in has been low for DEB_CYCLES samples and pressed again.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// Push-button front end for the PWM duty datapath: synchronise, debounce, step with auto-repeat,
// and hand the target duty to the PWM counter only at period boundaries.
module pwm_duty_ctrl #(
  parameter int DUTY_W        = 4,
  parameter int DUTY_RESET    = 8,
  parameter int STEP          = 1,
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_in,
  input  logic              dec_in,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_pending,
  output logic              at_max,
  output logic              at_min
);
  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LOAD  = REP_W'(REPEAT_CYCLES);
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
  localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;
  localparam logic [DUTY_W-1:0] DUTY_INIT = DUTY_W'(DUTY_RESET);
  localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);

  typedef enum logic [1:0] {IDLE, HELD_INC, HELD_DEC, LOCK} state_e;

  function automatic logic [DUTY_W-1:0] sat_inc(input logic [DUTY_W-1:0] v);
    logic [DUTY_W:0] sum;
    sum = {1'b0, v} + STEP_X;
    return (sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum[DUTY_W-1:0];
  endfunction

  function automatic logic [DUTY_W-1:0] sat_dec(input logic [DUTY_W-1:0] v);
    logic [DUTY_W:0] diff;
    diff = {1'b0, v} - STEP_X;
    return diff[DUTY_W] ? '0 : diff[DUTY_W-1:0];
  endfunction

  // Bit 0 is the increase button, bit 1 the decrease button throughout.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            blk_q, blk_d;
  logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0][DEB_W-1:0] low_cnt_q, low_cnt_d;

  // blk holds a button off after reset until it has been seen low for DEB_CYCLES samples.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      deb_d[b]     = deb_q[b];
      deb_cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (deb_cnt_q[b] == DEB_LAST) deb_d[b] = ~deb_q[b];
        else                          deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
      end
      blk_d[b]     = blk_q[b];
      low_cnt_d[b] = '0;
      if (blk_q[b] && !sync2_q[b]) begin
        if (low_cnt_q[b] == DEB_LAST) blk_d[b] = 1'b0;
        else                          low_cnt_d[b] = low_cnt_q[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      blk_q     <= '1;
      deb_cnt_q <= '0;
      low_cnt_q <= '0;
    end else begin
      sync1_q   <= {dec_in, inc_in};
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      blk_q     <= blk_d;
      deb_cnt_q <= deb_cnt_d;
      low_cnt_q <= low_cnt_d;
    end
  end

  logic inc_lvl, dec_lvl;
  assign inc_lvl = deb_q[0] & ~blk_q[0];
  assign dec_lvl = deb_q[1] & ~blk_q[1];

  state_e           state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             step_up, step_dn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (inc_lvl && dec_lvl) state_d = LOCK;
        else if (inc_lvl)       state_d = HELD_INC;
        else if (dec_lvl)       state_d = HELD_DEC;
      end
      HELD_INC: begin
        if (!inc_lvl)     state_d = IDLE;
        else if (dec_lvl) state_d = LOCK;
      end
      HELD_DEC: begin
        if (!dec_lvl)     state_d = IDLE;
        else if (inc_lvl) state_d = LOCK;
      end
      LOCK:    if (!inc_lvl && !dec_lvl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    rep_d   = rep_q;
    case (state_q)
      IDLE: begin
        if (inc_lvl && !dec_lvl) begin
          step_up = 1'b1;
          rep_d   = REP_LOAD;
        end else if (dec_lvl && !inc_lvl) begin
          step_dn = 1'b1;
          rep_d   = REP_LOAD;
        end
      end
      HELD_INC: begin
        if (inc_lvl && !dec_lvl) begin
          if (rep_q == REP_ONE) begin
            step_up = 1'b1;
            rep_d   = REP_LOAD;
          end else rep_d = rep_q - 1'b1;
        end
      end
      HELD_DEC: begin
        if (dec_lvl && !inc_lvl) begin
          if (rep_q == REP_ONE) begin
            step_dn = 1'b1;
            rep_d   = REP_LOAD;
          end else rep_d = rep_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  logic [DUTY_W-1:0] target_q, target_d, duty_q, duty_d;

  // duty takes the pre-step target, so a coincident step stays pending for a full period.
  always_comb begin
    target_d = target_q;
    if (step_up)      target_d = sat_inc(target_q);
    else if (step_dn) target_d = sat_dec(target_q);
    duty_d = period_end ? target_q : duty_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q <= DUTY_INIT;
      duty_q   <= DUTY_INIT;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
    end
  end

  assign duty         = duty_q;
  assign duty_pending = (target_q != duty_q);
  assign at_max       = (target_q == DUTY_MAX);
  assign at_min       = (target_q == '0);
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: each cycle's expected {duty,pending,at_max,at_min} is queued
// when stimulus is driven and compared one time unit after the clock edge.
module tb_pwm_duty_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inc_in = 1'b0;
  logic       dec_in = 1'b0;
  logic       period_end = 1'b0;
  logic [3:0] duty;
  logic       duty_pending, at_max, at_min;
  logic [6:0] obs;

  pwm_duty_ctrl dut (
    .clk(clk), .reset(reset), .inc_in(inc_in), .dec_in(dec_in), .period_end(period_end),
    .duty(duty), .duty_pending(duty_pending), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;
  assign obs = {duty, duty_pending, at_max, at_min};

  typedef struct {
    int         n;
    logic [6:0] obs;
  } exp_t;

  exp_t sb[$];
  int   tgt_m, duty_m;
  int   n_chk = 0;
  int   n_fail = 0;

  // Expected state after edge n: handoff sees the target before this edge's step.
  task automatic push_exp(input int n, input bit pe, input int stp);
    exp_t e;
    if (pe) duty_m = tgt_m;
    tgt_m = tgt_m + stp;
    if (tgt_m > 15) tgt_m = 15;
    if (tgt_m < 0) tgt_m = 0;
    e.n   = n;
    e.obs = {duty_m[3:0], tgt_m != duty_m, tgt_m == 15, tgt_m == 0};
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (obs !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_hold: got %b required %b", obs, 7'b1000000);
    end
    reset = 1'b0;
    tgt_m = 8;
    duty_m = 8;
    for (int n = 1; n <= 8; n++) begin
      push_exp(n, 1'b0, 0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.obs) begin
        n_fail++;
        $display("FAIL reset_idle edge %0d: got %b required %b", e.n, obs, e.obs);
      end
    end
  endtask

  task automatic test_single_press;
    exp_t e;
    for (int n = 1; n <= 64; n++) begin
      inc_in = (n >= 3 && n <= 12);
      period_end = (n % 32 == 0);
      push_exp(n, period_end, (n == 9) ? 1 : 0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.obs) begin
        n_fail++;
        $display("FAIL single_press edge %0d: got %b required %b", e.n, obs, e.obs);
      end
    end
    inc_in = 1'b0;
    period_end = 1'b0;
  endtask

  task automatic test_glitch;
    exp_t e;
    for (int n = 1; n <= 50; n++) begin
      inc_in = (n >= 3 && n <= 5) || (n >= 12 && n <= 31 && (n % 2 == 1));
      period_end = (n % 16 == 0);
      push_exp(n, period_end, 0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.obs) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got %b required %b", e.n, obs, e.obs);
      end
    end
    inc_in = 1'b0;
    period_end = 1'b0;
  endtask

  // Button held from edge 3 for 'hold' cycles; steps at 9, 25, 41, ... until the release is debounced.
  task automatic test_hold(input bit up, input int hold);
    exp_t  e;
    string nm;
    int    stp;
    nm = up ? "hold_inc" : "hold_dec";
    for (int n = 1; n <= hold + 20; n++) begin
      if (up) inc_in = (n >= 3 && n <= hold + 2);
      else    dec_in = (n >= 3 && n <= hold + 2);
      period_end = (n % 8 == 0);
      stp = (n >= 9 && (n - 9) % 16 == 0 && n <= hold + 8) ? (up ? 1 : -1) : 0;
      push_exp(n, period_end, stp);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.obs) begin
        n_fail++;
        $display("FAIL %s edge %0d: got %b required %b", nm, e.n, obs, e.obs);
      end
    end
    n_chk++;
    if ((up ? at_max : at_min) !== 1'b1 || duty !== (up ? 4'd15 : 4'd0)) begin
      n_fail++;
      $display("FAIL %s_limit: got duty=%0d max=%b min=%b required duty=%0d at limit",
               nm, duty, at_max, at_min, up ? 15 : 0);
    end
    period_end = 1'b0;
  endtask

  task automatic test_lock;
    exp_t e;
    for (int n = 1; n <= 110; n++) begin
      inc_in = (n >= 3 && n <= 30);
      dec_in = (n >= 3 && n <= 60) || (n >= 80 && n <= 89);
      period_end = (n % 16 == 0);
      push_exp(n, period_end, (n == 86) ? -1 : 0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.obs) begin
        n_fail++;
        $display("FAIL lock edge %0d: got %b required %b", e.n, obs, e.obs);
      end
    end
    inc_in = 1'b0;
    dec_in = 1'b0;
    period_end = 1'b0;
  endtask

  task automatic test_coincide;
    exp_t e;
    for (int n = 1; n <= 40; n++) begin
      inc_in = (n >= 3 && n <= 12);
      period_end = (n == 9) || (n == 30);
      push_exp(n, period_end, (n == 9) ? 1 : 0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.obs) begin
        n_fail++;
        $display("FAIL coincide edge %0d: got %b required %b", e.n, obs, e.obs);
      end
    end
    inc_in = 1'b0;
    period_end = 1'b0;
  endtask

  task automatic test_reset_held;
    exp_t e;
    for (int n = 1; n <= 12; n++) begin
      inc_in = (n >= 3);
      push_exp(n, 1'b0, (n == 9) ? 1 : 0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.obs) begin
        n_fail++;
        $display("FAIL held_pre edge %0d: got %b required %b", e.n, obs, e.obs);
      end
    end
    #3;
    reset = 1'b1;
    #1;
    n_chk++;
    if (obs !== 7'b1000000) begin
      n_fail++;
      $display("FAIL async_reset: got %b required %b", obs, 7'b1000000);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tgt_m = 8;
    duty_m = 8;
    for (int n = 1; n <= 75; n++) begin
      inc_in = (n <= 40) || (n >= 53 && n <= 62);
      period_end = (n % 8 == 0);
      push_exp(n, period_end, (n == 59) ? 1 : 0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs !== e.obs) begin
        n_fail++;
        $display("FAIL reset_held edge %0d: got %b required %b", e.n, obs, e.obs);
      end
    end
    inc_in = 1'b0;
    period_end = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_press;
    test_glitch;
    test_hold(1'b0, 200);
    test_hold(1'b1, 260);
    test_lock;
    test_coincide;
    test_reset_held;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
